// File: rtl/nios2_oci_trace_sched.sv
// Trace RAM write/read scheduler: captures compressed trace frames and
// arbitrates the single RAM port with debugger reads. Option: OCI_TRACE_WRAP_EN.
module nios2_oci_trace_sched #(
    parameter int ADDR_W     = 7,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trc_on,
    input  logic [29:0]       dct_buffer,
    input  logic [3:0]        dct_count,
    input  logic              dct_valid,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [33:0]       ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [33:0]       ram_rdata,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [33:0]       rd_data,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              trc_wrap,
    output logic              trc_full,
    output logic              trc_ovf
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, HALT} state_t;

    state_t        state, state_nxt;
    logic [33:0]   skid;
    logic          skid_full;
    logic [CW-1:0] defer_cnt;
    logic          trc_on_d;
    logic          re_d1;
    logic [33:0]   frame;
    logic          rise, new_frame, force_rd, wr_pend, grant;
    logic          do_write, wr_skid, wrap_w, load_skid, drop, drained;

    assign rise      = trc_on & ~trc_on_d;
    assign frame     = {dct_count, dct_buffer};
    assign new_frame = (state == CAPTURE) & trc_on & dct_valid;
    assign force_rd  = (defer_cnt == CW'(STARVE_MAX));
    assign wr_pend   = (state == CAPTURE) & (skid_full | new_frame);
    // reads win only when nothing is waiting to be written, or when starved
    assign grant     = reset_n & rd_req & (force_rd | ~wr_pend);
    assign do_write  = wr_pend & ~grant;
    assign wr_skid   = do_write & skid_full;
    assign wrap_w    = do_write & (wr_ptr == '1);
    // skid refills when it drains this cycle, or catches a frame a read displaced
    assign load_skid = new_frame & (grant ? ~skid_full : skid_full);
    assign drop      = new_frame & grant & skid_full;
    assign drained   = ~skid_full | wr_skid;

    assign ram_re    = grant;
    assign rd_ack    = grant;
    assign ram_we    = do_write;
    assign ram_addr  = grant ? rd_addr : wr_ptr;
    assign ram_wdata = skid_full ? skid : frame;

    // next-state: capture stops on wrap unless circular mode is built in
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (trc_on) state_nxt = CAPTURE;
            CAPTURE: begin
`ifdef OCI_TRACE_WRAP_EN
                if (!trc_on && drained) state_nxt = IDLE;
`else
                if (wrap_w) state_nxt = HALT;
                else if (!trc_on && drained) state_nxt = IDLE;
`endif
            end
            HALT: if (!trc_on) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state, write pointer and sticky capture status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            trc_on_d <= 1'b0;
            wr_ptr   <= '0;
            trc_full <= 1'b0;
            trc_wrap <= 1'b0;
            trc_ovf  <= 1'b0;
        end else begin
            state    <= state_nxt;
            trc_on_d <= trc_on;
            if (rise) begin
                wr_ptr   <= '0;
                trc_full <= 1'b0;
                trc_wrap <= 1'b0;
                trc_ovf  <= 1'b0;
            end else begin
                if (do_write) wr_ptr <= wr_ptr + ADDR_W'(1);
                if (wrap_w) begin
                    trc_full <= 1'b1;
`ifdef OCI_TRACE_WRAP_EN
                    trc_wrap <= 1'b1;
`else
                    trc_wrap <= 1'b0;
`endif
                end
                if (drop) trc_ovf <= 1'b1;
            end
        end
    end

    // one-entry skid holding a frame displaced by a forced read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_full <= 1'b0;
            skid      <= '0;
        end else if (rise) begin
            skid_full <= 1'b0;
        end else if (load_skid) begin
            skid      <= frame;
            skid_full <= 1'b1;
        end else if (wr_skid) begin
            skid_full <= 1'b0;
        end
    end

    // read starvation counter, saturating
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            defer_cnt <= '0;
        end else if (grant) begin
            defer_cnt <= '0;
        end else if (rd_req && !force_rd) begin
            defer_cnt <= defer_cnt + CW'(1);
        end
    end

    // fixed two-cycle read return pipeline
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            re_d1    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            re_d1    <= grant;
            rd_valid <= re_d1;
            if (re_d1) rd_data <= ram_rdata;
        end
    end

endmodule
